bus_arbiter: RTL and testbench

Round-robin arbiter that shares the single system bus between NUM_MASTERS biu_master-based requesters, such as the UART test master and a future DMA or debug master.
- Issues a registered one-hot grant.
- The grantee holds the bus until it drops its request.
- Enforces a fixed dead-cycle handover between owners, so two masters never drive the bus in adjacent cycles.
- Sits beside the bus_if instance in the top level; bus muxing is steered by o_gnt_id.

---
 rtl/bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: registered one-hot grant, owner keeps the bus until it drops its request.
// Latency: request sampled at edge N -> grant after edge N; release -> HANDOVER_CYCLES dead cycles.
// Backpressure: none; losers keep requesting. Define BUS_ARB_TIMEOUT_EN to revoke after HOLD_LIMIT cycles.
module bus_arbiter #(
  parameter int  NUM_MASTERS     = 2,
  parameter int  HANDOVER_CYCLES = 1,
  parameter int  HOLD_LIMIT      = 256,
  localparam int ID_W            = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] i_req,
  output logic [NUM_MASTERS-1:0] o_gnt,
  output logic                   o_gnt_valid,
  output logic [ID_W-1:0]        o_gnt_id,
  output logic                   o_timeout,
  output logic [ID_W-1:0]        o_timeout_id
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HANDOVER} state_e;

  localparam logic [3:0]      HO_LOAD = 4'(HANDOVER_CYCLES - 1);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_MASTERS - 1);

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        rr_q, rr_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic                   vld_q, vld_d;
  logic [3:0]             ho_q, ho_d;

  logic [NUM_MASTERS-1:0] req_rot;
  logic [ID_W:0]          off;
  logic [ID_W:0]          sum;
  logic                   found;
  logic [ID_W-1:0]        pick;
  logic                   owner_req;
  logic                   revoke;
  logic                   arb;
  logic [ID_W-1:0]        next_rr;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_LIMIT - 1);
  logic [15:0]     hold_q, hold_d;
  logic            to_q, to_d;
  logic [ID_W-1:0] to_id_q, to_id_d;
`endif

  // Rotate requests so bit 0 is the highest-priority master, then take the lowest set bit.
  always_comb begin
    req_rot = NUM_MASTERS'({i_req, i_req} >> rr_q);
    found   = 1'b0;
    off     = '0;
    for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        found = 1'b1;
        off   = (ID_W+1)'(j);
      end
    end
    sum = {1'b0, rr_q} + off;
    if (sum >= (ID_W+1)'(NUM_MASTERS)) sum = sum - (ID_W+1)'(NUM_MASTERS);
    pick = sum[ID_W-1:0];
  end

  // The released owner moves to the back of the queue.
  assign owner_req = |(i_req & gnt_q);
  assign next_rr   = (id_q == LAST_ID) ? '0 : id_q + ID_W'(1);

  // Next-state: arbitrate from IDLE or at the end of the dead time; hold otherwise.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    vld_d   = vld_q;
    ho_d    = ho_q;
    arb     = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    hold_d  = hold_q;
    to_d    = 1'b0;
    to_id_d = to_id_q;
    revoke  = owner_req && (hold_q == HOLD_LAST);
`else
    revoke  = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: arb = 1'b1;
      S_GRANT: begin
        if (!owner_req || revoke) begin
          state_d = S_HANDOVER;
          gnt_d   = '0;
          id_d    = '0;
          vld_d   = 1'b0;
          rr_d    = next_rr;
          ho_d    = HO_LOAD;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        if (revoke) begin
          to_d    = 1'b1;
          to_id_d = id_q;
        end
        hold_d = hold_q + 16'd1;
`endif
      end
      S_HANDOVER: begin
        if (ho_q == 4'd0) arb = 1'b1;
        else              ho_d = ho_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
    if (arb) begin
      if (found) begin
        state_d = S_GRANT;
        gnt_d   = NUM_MASTERS'(1) << pick;
        id_d    = pick;
        vld_d   = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
        hold_d  = '0;
`endif
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
      vld_q   <= 1'b0;
      ho_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      vld_q   <= vld_d;
      ho_q    <= ho_d;
    end
  end

  assign o_gnt       = gnt_q;
  assign o_gnt_valid = vld_q;
  assign o_gnt_id    = id_q;

`ifdef BUS_ARB_TIMEOUT_EN
  // Hold counter and timeout reporting registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      to_q    <= 1'b0;
      to_id_q <= '0;
    end else begin
      hold_q  <= hold_d;
      to_q    <= to_d;
      to_id_q <= to_id_d;
    end
  end

  assign o_timeout    = to_q;
  assign o_timeout_id = to_id_q;
`else
  assign o_timeout    = 1'b0;
  assign o_timeout_id = '0;

  // HOLD_LIMIT has no effect in this build; an out-of-range value still shows up in the hierarchy.
  if (HOLD_LIMIT < 2 || HOLD_LIMIT > 65535) begin : g_hold_limit_out_of_range
  end
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (3 masters/1 dead cycle, 2 masters/2 dead cycles)
// checked every cycle against a request-level ownership model plus directed literal checks.
// Define BUS_ARB_TIMEOUT_EN for both bench and RTL to exercise the forced-revoke path.
module tb_bus_arbiter;

  localparam int HOLD = 8;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req_a = '0;
  logic [1:0] req_b = '0;

  logic [2:0] gnt_a;
  logic       vld_a;
  logic [1:0] id_a;
  logic       to_a;
  logic [1:0] toid_a;
  logic [1:0] gnt_b;
  logic       vld_b;
  logic       id_b;
  logic       to_b;
  logic       toid_b;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  cmp_en   = 1'b0;
  int  bad      = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.NUM_MASTERS(3), .HANDOVER_CYCLES(1), .HOLD_LIMIT(HOLD)) u_a (
    .clk(clk), .rst(rst), .i_req(req_a), .o_gnt(gnt_a), .o_gnt_valid(vld_a),
    .o_gnt_id(id_a), .o_timeout(to_a), .o_timeout_id(toid_a)
  );

  bus_arbiter #(.NUM_MASTERS(2), .HANDOVER_CYCLES(2), .HOLD_LIMIT(HOLD)) u_b (
    .clk(clk), .rst(rst), .i_req(req_b), .o_gnt(gnt_b), .o_gnt_valid(vld_b),
    .o_gnt_id(id_b), .o_timeout(to_b), .o_timeout_id(toid_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Ownership model: who owns the bus, how many dead edges remain, who is first in line.
  int m_owner[2];
  int m_wait[2];
  int m_rr[2];
  int m_held[2];
  int m_toid[2];
  int m_to[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int r;
      int n;
      int h;
      int pick;
      r = (k == 0) ? int'(req_a) : int'(req_b);
      n = (k == 0) ? 3 : 2;
      h = (k == 0) ? 1 : 2;
      if (rst) begin
        m_owner[k] = -1; m_wait[k] = 0; m_rr[k] = 0;
        m_held[k]  = 0;  m_to[k]   = 0; m_toid[k] = 0;
      end else begin
        m_to[k] = 0;
        if (m_owner[k] >= 0) begin
          if (((r >> m_owner[k]) & 1) == 0 || (TO_EN && m_held[k] == HOLD - 1)) begin
            if (((r >> m_owner[k]) & 1) != 0) begin
              m_to[k]   = 1;
              m_toid[k] = m_owner[k];
            end
            m_rr[k]    = (m_owner[k] + 1) % n;
            m_owner[k] = -1;
            m_wait[k]  = h;
          end else begin
            m_held[k]++;
          end
        end else if (m_wait[k] > 1) begin
          m_wait[k]--;
        end else begin
          m_wait[k] = 0;
          pick = -1;
          for (int i = 0; i < n; i++)
            if (pick < 0 && ((r >> ((m_rr[k] + i) % n)) & 1) != 0) pick = (m_rr[k] + i) % n;
          if (pick >= 0) begin
            m_owner[k] = pick;
            m_held[k]  = 0;
          end
        end
      end
    end
  end

  task automatic cmp(input int k, input int g, input int v, input int id, input int t, input int tid);
    chk($sformatf("u%0d_gnt", k),    g,   (m_owner[k] >= 0) ? (1 << m_owner[k]) : 0);
    chk($sformatf("u%0d_vld", k),    v,   (m_owner[k] >= 0) ? 1 : 0);
    chk($sformatf("u%0d_id", k),     id,  (m_owner[k] >= 0) ? m_owner[k] : 0);
    chk($sformatf("u%0d_to", k),     t,   m_to[k]);
    chk($sformatf("u%0d_to_id", k),  tid, m_toid[k]);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      cmp(0, int'(gnt_a), int'(vld_a), int'(id_a), int'(to_a), int'(toid_a));
      cmp(1, int'(gnt_b), int'(vld_b), int'(id_b), int'(to_b), int'(toid_b));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] mask;
    int         id;

    // Reset and idle
    step();
    cmp_en = 1'b1;
    step();
    step();
    chk("rst_gnt_a", int'(gnt_a), 0);
    chk("rst_vld_a", int'(vld_a), 0);
    chk("rst_id_a", int'(id_a), 0);
    chk("rst_to_a", int'(to_a), 0);
    chk("rst_gnt_b", int'(gnt_b), 0);
    rst = 1'b0;
    repeat (10) step();
    chk("idle_gnt_a", int'(gnt_a), 0);
    chk("idle_gnt_b", int'(gnt_b), 0);

    // Single request held 4 grant cycles, then one dead cycle
    req_a = 3'b001;
    step();
    chk("single_gnt", int'(gnt_a), 1);
    chk("single_id", int'(id_a), 0);
    chk("single_vld", int'(vld_a), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("single_hold", int'(gnt_a), 1);
    end
    req_a = 3'b000;
    step();
    chk("single_release", int'(gnt_a), 0);
    step();
    chk("single_idle", int'(gnt_a), 0);

    // Reset asserted mid-grant clears on the next edge
    req_a = 3'b010;
    step();
    chk("pre_rst_gnt", int'(gnt_a), 2);
    chk("pre_rst_id", int'(id_a), 1);
    step();
    rst = 1'b1;
    step();
    chk("midrst_gnt", int'(gnt_a), 0);
    chk("midrst_vld", int'(vld_a), 0);
    chk("midrst_id", int'(id_a), 0);
    rst   = 1'b0;
    req_a = 3'b000;
    step();

    // Round robin: 0,1,2,0,1 with one dead cycle between owners
    req_a = 3'b111;
    for (int r = 0; r < 5; r++) begin
      id = r % 3;
      step();
      chk("rr_gnt", int'(gnt_a), 1 << id);
      chk("rr_model_owner", m_owner[0], id);
      step();
      chk("rr_hold", int'(gnt_a), 1 << id);
      mask  = 3'b001 << id;
      req_a = 3'b111 & ~mask;
      step();
      chk("rr_gap", int'(gnt_a), 0);
      req_a = (r == 4) ? 3'b000 : 3'b111;
    end
    step();
    step();

    // Simultaneous release/request on the 2-master, 2-dead-cycle instance
    req_b = 2'b01;
    step();
    chk("sim_gnt0", int'(gnt_b), 1);
    chk("sim_id0", int'(id_b), 0);
    step();
    chk("sim_hold0", int'(gnt_b), 1);
    req_b = 2'b10;
    step();
    chk("sim_gap1", int'(gnt_b), 0);
    req_b = 2'b11;
    step();
    chk("sim_gap2", int'(gnt_b), 0);
    step();
    chk("sim_gnt1", int'(gnt_b), 2);
    chk("sim_id1", int'(id_b), 1);
    step();
    chk("sim_wait0", int'(gnt_b), 2);
    req_b = 2'b01;
    step();
    chk("sim_gap3", int'(gnt_b), 0);
    step();
    chk("sim_gap4", int'(gnt_b), 0);
    step();
    chk("sim_gnt0_again", int'(gnt_b), 1);
    chk("sim_id0_again", int'(id_b), 0);
    req_b = 2'b00;
    repeat (3) step();

    // Master 1 holds forever while master 0 waits
    req_a = 3'b010;
    step();
    chk("to_gnt1", int'(gnt_a), 2);
    req_a = 3'b011;
    for (int i = 1; i < HOLD; i++) begin
      step();
      chk("to_hold", int'(gnt_a), 2);
      chk("to_quiet", int'(to_a), 0);
    end
`ifdef BUS_ARB_TIMEOUT_EN
    step();
    chk("to_revoke_gnt", int'(gnt_a), 0);
    chk("to_pulse", int'(to_a), 1);
    chk("to_id", int'(toid_a), 1);
    chk("to_model_pulse", m_to[0], 1);
    step();
    chk("to_next_gnt", int'(gnt_a), 1);
    chk("to_pulse_end", int'(to_a), 0);
    chk("to_id_hold", int'(toid_a), 1);
    chk("to_model_toid", m_toid[0], 1);
`else
    for (int i = 0; i < 1000; i++) begin
      step();
      if (gnt_a != 3'b010 || to_a != 1'b0) bad++;
    end
    chk("hold_unbounded", bad, 0);
    chk("hold_model_owner", m_owner[0], 1);
`endif
    req_a = 3'b000;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
